// File: rtl/btn_scan.sv
// 4x4 button-matrix scanner. Drives one column low per slot, samples the
// active-low rows once per slot, debounces all 16 keys independently and
// emits one-cycle press events with the key code (k = col*4 + row).
// Optional auto-repeat of the held key is enabled by defining BTN_SCAN_AUTOREPEAT_EN.
module btn_scan #(
    parameter int unsigned SCAN_DIV     = 16,
    parameter int unsigned DEBOUNCE     = 4,
    parameter int unsigned REPEAT_DELAY = 50000000,
    parameter int unsigned REPEAT_RATE  = 10000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  btn_y,
    output logic [3:0]  btn_x,
    output logic [15:0] key_state,
    output logic        key_valid,
    output logic [3:0]  key_code
);

    localparam int unsigned DivW = $clog2(SCAN_DIV);
    localparam int unsigned CntW = $clog2(DEBOUNCE + 1);

    logic [DivW-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]      col_q, col_d;
    logic            sample;

    // Row sample captured at the end of the sampling cycle, processed one edge later.
    logic            smp_vld_q;
    logic [1:0]      smp_col_q;
    logic [3:0]      smp_raw_q;

    logic [CntW-1:0] cnt_q [16];
    logic [CntW-1:0] cnt_d [16];
    logic [15:0]     key_state_q, key_state_d;
    logic [15:0]     pending_q, pending_d;
    logic [15:0]     press;
    logic [15:0]     clr;
    logic [15:0]     rep_set;
    logic            key_valid_q, key_valid_d;
    logic [3:0]      key_code_q, key_code_d;

    // Column scan timing: sample on the last cycle of the slot, then advance.
    always_comb begin
        sample    = (div_cnt_q == DivW'(SCAN_DIV - 1));
        div_cnt_d = sample ? '0 : div_cnt_q + DivW'(1);
        col_d     = sample ? col_q + 2'd1 : col_q;
    end

    // Per-key debounce on the captured row sample of the scanned column.
    always_comb begin
        logic [3:0]      k;
        logic [CntW-1:0] inc;
        k           = '0;
        inc         = '0;
        cnt_d       = cnt_q;
        key_state_d = key_state_q;
        if (smp_vld_q) begin
            for (int r = 0; r < 4; r++) begin
                k = {smp_col_q, r[1:0]};
                if (smp_raw_q[r] == key_state_q[k]) begin
                    cnt_d[k] = '0;
                end else begin
                    inc = cnt_q[k] + CntW'(1);
                    if (inc == CntW'(DEBOUNCE)) begin
                        key_state_d[k] = ~key_state_q[k];
                        cnt_d[k]       = '0;
                    end else begin
                        cnt_d[k] = inc;
                    end
                end
            end
        end
    end

    // Event queue: report the lowest pending key; a same-cycle set beats the clear.
    always_comb begin
        press       = key_state_d & ~key_state_q;
        key_valid_d = |pending_q;
        key_code_d  = key_code_q;
        clr         = '0;
        for (int k = 15; k >= 0; k--) begin
            if (pending_q[k]) begin
                key_code_d = k[3:0];
            end
        end
        if (key_valid_d) begin
            clr[key_code_d] = 1'b1;
        end
        pending_d = (pending_q & ~clr) | press | rep_set;
    end

`ifdef BTN_SCAN_AUTOREPEAT_EN
    localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RepW   = $clog2(RepMax + 1);

    logic [3:0]      rep_key_q, rep_key_d;
    logic [RepW-1:0] rep_cnt_q, rep_cnt_d;
    logic            rep_armed_q, rep_armed_d;
    logic            rep_first_q, rep_first_d;

    // Repeat timer for the most recently emitted key; a fresh press re-arms it.
    always_comb begin
        logic [RepW-1:0] limit;
        limit       = rep_first_q ? RepW'(REPEAT_DELAY) : RepW'(REPEAT_RATE);
        rep_key_d   = rep_key_q;
        rep_cnt_d   = rep_cnt_q;
        rep_armed_d = rep_armed_q;
        rep_first_d = rep_first_q;
        rep_set     = '0;
        if (rep_armed_q) begin
            if (!key_state_q[rep_key_q]) begin
                rep_armed_d = 1'b0;
                rep_cnt_d   = '0;
            end else if (rep_cnt_q + RepW'(1) == limit) begin
                rep_set[rep_key_q] = 1'b1;
                rep_cnt_d          = '0;
                rep_first_d        = 1'b0;
            end else begin
                rep_cnt_d = rep_cnt_q + RepW'(1);
            end
        end
        // Repeat events of the armed key must not restart the delay.
        if (key_valid_d && (!rep_armed_q || key_code_d != rep_key_q)) begin
            rep_key_d   = key_code_d;
            rep_cnt_d   = '0;
            rep_armed_d = 1'b1;
            rep_first_d = 1'b1;
        end
    end

    // Repeat state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rep_key_q   <= '0;
            rep_cnt_q   <= '0;
            rep_armed_q <= 1'b0;
            rep_first_q <= 1'b0;
        end else begin
            rep_key_q   <= rep_key_d;
            rep_cnt_q   <= rep_cnt_d;
            rep_armed_q <= rep_armed_d;
            rep_first_q <= rep_first_d;
        end
    end
`else
    // No auto-repeat: pending bits are only set by presses.
    always_comb begin
        rep_set = '0;
    end
`endif

    // Scanner, debounce and event state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q   <= '0;
            col_q       <= '0;
            smp_vld_q   <= 1'b0;
            smp_col_q   <= '0;
            smp_raw_q   <= '0;
            for (int k = 0; k < 16; k++) begin
                cnt_q[k] <= '0;
            end
            key_state_q <= '0;
            pending_q   <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            col_q     <= col_d;
            smp_vld_q <= sample;
            if (sample) begin
                smp_col_q <= col_q;
                smp_raw_q <= ~btn_y;
            end
            cnt_q       <= cnt_d;
            key_state_q <= key_state_d;
            pending_q   <= pending_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
        end
    end

    assign btn_x     = ~(4'b0001 << col_q);
    assign key_state = key_state_q;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;

endmodule
